// File: rtl/sched_tbl_reader_pkg.sv
// Shared NI definitions for the schedule-table reader:
// entry layout, table geometry and config sub-addresses.
package sched_tbl_reader_pkg;

    localparam int STBL_AW = 8;
    localparam int MODE_W  = 2;
    localparam int N_MODES = 1 << MODE_W;
    localparam int ROUTE_W = 16;
    localparam int DMA_W   = 8;
    localparam int T2N_W   = 4;
    localparam int CFG_AW  = 14;
    localparam int CFG_DW  = 32;
    localparam int WIN_W   = 2 * STBL_AW;

    localparam int ROUTE_LSB = 0;
    localparam int DMA_LSB   = 16;
    localparam int T2N_LSB   = 24;
    localparam int PV_BIT    = 28;
    localparam int ENTRY_W   = PV_BIT + 1;

    localparam logic [CFG_AW-1:0] STBL_BASE   = 14'h000;
    localparam logic [CFG_AW-1:0] MODE_BASE   = 14'h800;
    localparam logic [CFG_AW-1:0] MC_REQ_ADDR = 14'h804;

    typedef struct packed {
        logic               pkt_valid;
        logic [T2N_W-1:0]   t2n;
        logic [DMA_W-1:0]   dma_num;
        logic [ROUTE_W-1:0] route;
    } stbl_entry_t;

    typedef enum logic [2:0] {
        CK_NONE,
        CK_TBL,
        CK_WIN,
        CK_MCR,
        CK_ERR
    } cfg_kind_e;

    function automatic stbl_entry_t unpack_entry(
        input logic [ENTRY_W-1:0] w
    );
        stbl_entry_t e;
        e.route     = w[ROUTE_LSB +: ROUTE_W];
        e.dma_num   = w[DMA_LSB +: DMA_W];
        e.t2n       = w[T2N_LSB +: T2N_W];
        e.pkt_valid = w[PV_BIT];
        return e;
    endfunction

endpackage

// File: rtl/sched_tbl_reader_if.sv
// Config-bus slave interface of the schedule-table reader.
// Request fields come from the decoder; response is registered.
interface sched_tbl_reader_if;
    import sched_tbl_reader_pkg::*;

    logic [CFG_AW-1:0] config_addr;
    logic              config_en;
    logic              config_wr;
    logic [CFG_DW-1:0] config_wdata;
    logic              sel;
    logic [CFG_DW-1:0] config_slv_rdata;
    logic              config_slv_error;

    modport master (
        output config_addr,
        output config_en,
        output config_wr,
        output config_wdata,
        output sel,
        input  config_slv_rdata,
        input  config_slv_error
    );

    modport slave (
        input  config_addr,
        input  config_en,
        input  config_wr,
        input  config_wdata,
        input  sel,
        output config_slv_rdata,
        output config_slv_error
    );

endinterface

// File: rtl/sched_tbl_ram.sv
// True dual-port schedule RAM: A = config R/W, B = slot read.
// Both ports read-first with one cycle of latency.
module sched_tbl_ram
    import sched_tbl_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               a_en,
    input  logic               a_we,
    input  logic [STBL_AW-1:0] a_addr,
    input  logic [ENTRY_W-1:0] a_wdata,
    output logic [ENTRY_W-1:0] a_rdata,
    input  logic               b_en,
    input  logic [STBL_AW-1:0] b_addr,
    output logic [ENTRY_W-1:0] b_rdata
);

    logic [ENTRY_W-1:0] mem [2**STBL_AW];

    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Only the output registers reset; array contents persist.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en) begin
                a_rdata <= mem[a_addr];
            end
            if (b_en) begin
                b_rdata <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/sched_tbl_reader.sv
// Schedule-table side of the NI TDM slot interface:
// slot lookup, config access and mode-window switching.
module sched_tbl_reader
    import sched_tbl_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    sched_tbl_reader_if.slave  cfg,
    input  logic [STBL_AW-1:0] stbl_idx,
    input  logic               stbl_idx_en,
    input  logic               period_boundary,
    output logic [T2N_W-1:0]   t2n,
    output logic [ROUTE_W-1:0] route,
    output logic [DMA_W-1:0]   dma_num,
    output logic               pkt_valid,
    output logic [STBL_AW-1:0] stbl_min,
    output logic [STBL_AW-1:0] stbl_maxp1,
    output logic [MODE_W-1:0]  cur_mode
);

    cfg_kind_e          kind;
    logic               acc;
    logic               is_tbl;
    logic               is_win;
    logic               is_mcr;
    logic [MODE_W-1:0]  win_idx;
    logic [CFG_DW-1:0]  rsp_data_d;

    logic [WIN_W-1:0]   win_q [N_MODES];
    logic [MODE_W-1:0]  cur_mode_q;
    logic [MODE_W-1:0]  next_mode_q;
    logic               pending_q;
    logic               rsp_tbl_q;
    logic               rsp_err_q;
    logic [CFG_DW-1:0]  rsp_data_q;

    logic [ENTRY_W-1:0] ram_a_rdata;
    logic [ENTRY_W-1:0] ram_b_rdata;
    stbl_entry_t        ent;
    logic               unused_wdata;

    assign acc     = cfg.sel & cfg.config_en;
    assign win_idx = cfg.config_addr[MODE_W-1:0];

    assign is_tbl = (cfg.config_addr[13:11] == STBL_BASE[13:11])
                 && (cfg.config_addr[10:STBL_AW] == '0);
    assign is_win = (cfg.config_addr[13:11] == MODE_BASE[13:11])
                 && (cfg.config_addr[10:MODE_W] == '0);
    assign is_mcr = (cfg.config_addr == MC_REQ_ADDR);

    always_comb begin
        kind = CK_NONE;
        if (acc) begin
            kind = CK_ERR;
            unique case (1'b1)
                is_tbl:  kind = CK_TBL;
                is_win:  kind = CK_WIN;
                is_mcr:  kind = CK_MCR;
                default: kind = CK_ERR;
            endcase
        end
    end

    always_comb begin
        rsp_data_d = '0;
        unique case (kind)
            CK_WIN: rsp_data_d = {{(CFG_DW-WIN_W){1'b0}}, win_q[win_idx]};
            CK_MCR: rsp_data_d = {{(CFG_DW-1-MODE_W){1'b0}},
                                  pending_q, cur_mode_q};
            default: rsp_data_d = '0;
        endcase
    end

    // Request write beats the boundary clear so a same-cycle
    // request waits for the following boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_MODES; i++) begin
                win_q[i] <= '0;
            end
            cur_mode_q  <= '0;
            next_mode_q <= '0;
            pending_q   <= 1'b0;
            rsp_tbl_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_tbl_q  <= (kind == CK_TBL) && !cfg.config_wr;
            rsp_err_q  <= (kind == CK_ERR);
            rsp_data_q <= rsp_data_d;
            if (kind == CK_WIN && cfg.config_wr) begin
                win_q[win_idx] <= cfg.config_wdata[WIN_W-1:0];
            end
            if (period_boundary && pending_q) begin
                cur_mode_q <= next_mode_q;
                pending_q  <= 1'b0;
            end
            if (kind == CK_MCR && cfg.config_wr) begin
                pending_q   <= 1'b1;
                next_mode_q <= cfg.config_wdata[MODE_W-1:0];
            end
        end
    end

    sched_tbl_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .a_en    (kind == CK_TBL),
        .a_we    (cfg.config_wr),
        .a_addr  (cfg.config_addr[STBL_AW-1:0]),
        .a_wdata (cfg.config_wdata[ENTRY_W-1:0]),
        .a_rdata (ram_a_rdata),
        .b_en    (stbl_idx_en),
        .b_addr  (stbl_idx),
        .b_rdata (ram_b_rdata)
    );

    assign unused_wdata = ^cfg.config_wdata[CFG_DW-1:ENTRY_W];

    assign cfg.config_slv_rdata = rsp_tbl_q
        ? {{(CFG_DW-ENTRY_W){1'b0}}, ram_a_rdata}
        : rsp_data_q;
    assign cfg.config_slv_error = rsp_err_q;

    assign ent       = unpack_entry(ram_b_rdata);
    assign t2n       = ent.t2n;
    assign route     = ent.route;
    assign dma_num   = ent.dma_num;
    assign pkt_valid = ent.pkt_valid;

    assign cur_mode   = cur_mode_q;
    assign stbl_min   = win_q[cur_mode_q][STBL_AW-1:0];
    assign stbl_maxp1 = win_q[cur_mode_q][WIN_W-1:STBL_AW];

endmodule
